// File: rtl/sd_block_buffer_pkg.sv
// SD block buffer shared constants.
// Sizes, write-FSM encoding and the SD data-start token.
package sd_buffer_pkg;

  localparam int DATA_WIDTH  = 8;
  localparam int BLOCK_BYTES = 512;
  localparam int ADDR_BITS   = 9;
  localparam int SYNC_STAGES = 2;

  localparam logic [7:0] START_TOKEN = 8'hFE;

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_FILL = 1'b1;

endpackage

// File: rtl/sd_block_buffer_if.sv
// SD byte stream in, video byte fetch out.
// slave = buffer side, master = SD controller / fetcher side.
interface sd_block_buffer_if;
  import sd_buffer_pkg::*;

  logic [DATA_WIDTH-1:0] SD_Data;
  logic                  SD_DataClk;
  logic                  SD_Enable;
  logic                  BlockReq;
  logic                  RdReq;
  logic [DATA_WIDTH-1:0] RdData;
  logic                  RdValid;
  logic                  RdLast;
  logic [1:0]            BanksFull;
  logic                  Overflow;
  logic                  Underflow;
  logic                  ShortBlock;

  modport slave (
    input  SD_Data, SD_DataClk, SD_Enable, RdReq,
    output BlockReq, RdData, RdValid, RdLast,
    output BanksFull, Overflow, Underflow, ShortBlock
  );

  modport master (
    output SD_Data, SD_DataClk, SD_Enable, RdReq,
    input  BlockReq, RdData, RdValid, RdLast,
    input  BanksFull, Overflow, Underflow, ShortBlock
  );

endinterface

// File: rtl/sd_block_buffer_ram.sv
// Two-bank byte RAM: one write port, one registered read port.
// Address is {bank, offset}; contents are never cleared.
module sd_bank_ram #(
  parameter int DW = 8,
  parameter int AW = 10
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [0:(2**AW)-1];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Output register holds its value when no read is issued.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sd_block_buffer.sv
// Ping-pong buffer between the SD SPI reader and the pixel fetcher.
// SD strobes are synchronized; one bank fills while the other drains.
module sd_block_buffer
  import sd_buffer_pkg::*;
(
  input logic            MasterCLK,
  input logic            Reset,
  sd_block_buffer_if.slave bus
);

  localparam logic [ADDR_BITS-1:0] LAST =
    ADDR_BITS'(BLOCK_BYTES - 1);

  logic [SYNC_STAGES-1:0] dclk_q, en_q;
  logic                   dclk_prev_q, en_prev_q;
  logic                   dclk_s, en_s;
  logic                   byte_stb, en_fall;

  logic [0:0]           state_q, state_d;
  logic [ADDR_BITS-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_BITS-1:0] rd_cnt_q, rd_cnt_d;
  logic                 wr_bank_q, wr_bank_d;
  logic                 rd_bank_q, rd_bank_d;
  logic [1:0]           full_q, full_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;
  logic                 short_q, short_d;
  logic                 breq_q, breq_d;
  logic                 rvalid_q, rlast_q, rlast_d;
  logic                 we, re;

  assign dclk_s   = dclk_q[SYNC_STAGES-1];
  assign en_s     = en_q[SYNC_STAGES-1];
  assign byte_stb = dclk_s & ~dclk_prev_q & en_s;
  assign en_fall  = ~en_s & en_prev_q;

  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    short_d   = 1'b0;
    rlast_d   = 1'b0;
    we        = 1'b0;
    re        = 1'b0;

    unique case (state_q)
      W_IDLE: begin
        if (byte_stb) begin
          if (full_q[wr_bank_q]) begin
            ovf_d = 1'b1;
          end else begin
            we       = 1'b1;
            wr_cnt_d = wr_cnt_q + 1'b1;
            state_d  = W_FILL;
          end
        end
      end
      W_FILL: begin
        if (byte_stb) begin
          we = 1'b1;
          if (wr_cnt_q == LAST) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d = ~wr_bank_q;
            wr_cnt_d  = '0;
            state_d   = W_IDLE;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end else if (en_fall && wr_cnt_q != '0) begin
          short_d  = 1'b1;
          wr_cnt_d = '0;
          state_d  = W_IDLE;
        end
      end
      default: state_d = W_IDLE;
    endcase

    // Fill completes only on an empty bank and drain only on a
    // full one, so both flag updates never hit the same bank.
    if (bus.RdReq) begin
      if (full_q[rd_bank_q]) begin
        re = 1'b1;
        if (rd_cnt_q == LAST) begin
          rlast_d           = 1'b1;
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = ~rd_bank_q;
          rd_cnt_d          = '0;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end else begin
        unf_d = 1'b1;
      end
    end

    breq_d = (state_d == W_IDLE) & ~full_d[wr_bank_d];
  end

  always_ff @(posedge MasterCLK or negedge Reset) begin
    if (!Reset) begin
      dclk_q      <= '0;
      en_q        <= '0;
      dclk_prev_q <= 1'b0;
      en_prev_q   <= 1'b0;
      state_q     <= W_IDLE;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      full_q      <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      short_q     <= 1'b0;
      breq_q      <= 1'b0;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
    end else begin
      dclk_q      <= {dclk_q[SYNC_STAGES-2:0], bus.SD_DataClk};
      en_q        <= {en_q[SYNC_STAGES-2:0], bus.SD_Enable};
      dclk_prev_q <= dclk_s;
      en_prev_q   <= en_s;
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      full_q      <= full_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      short_q     <= short_d;
      breq_q      <= breq_d;
      rvalid_q    <= re;
      rlast_q     <= rlast_d;
    end
  end

  sd_bank_ram #(
    .DW(DATA_WIDTH),
    .AW(ADDR_BITS + 1)
  ) u_ram (
    .clk_i   (MasterCLK),
    .rst_ni  (Reset),
    .we_i    (we),
    .waddr_i ({wr_bank_q, wr_cnt_q}),
    .wdata_i (bus.SD_Data),
    .re_i    (re),
    .raddr_i ({rd_bank_q, rd_cnt_q}),
    .rdata_o (bus.RdData)
  );

  assign bus.BlockReq   = breq_q;
  assign bus.RdValid    = rvalid_q;
  assign bus.RdLast     = rlast_q;
  assign bus.BanksFull  = full_q;
  assign bus.Overflow   = ovf_q;
  assign bus.Underflow  = unf_q;
  assign bus.ShortBlock = short_q;

endmodule

// File: tb/tb_sd_block_buffer.sv
// Directed bench for sd_block_buffer.
// Byte patterns are generated here and compared on read-back.
module tb_sd_block_buffer;
  import sd_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sd_block_buffer_if bus();

  sd_block_buffer dut (
    .MasterCLK (clk),
    .Reset     (rst_n),
    .bus       (bus)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] pat(input int k, input int i);
    logic [31:0] v;
    unique case (k)
      0: v = i;
      1: v = i * 3 + 7;
      2: v = i ^ 32'h5A;
      3: v = ~i;
      4: v = i + 1;
      default: v = i ^ 32'hC3;
    endcase
    return v[7:0];
  endfunction

  // One SD byte period: strobe high two cycles, low two cycles.
  task automatic strobe(input logic [7:0] b);
    @(negedge clk);
    bus.SD_Data = b;
    bus.SD_DataClk = 1'b1;
    repeat (2) @(negedge clk);
    bus.SD_DataClk = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic rd(output logic [7:0] d,
                    output logic v, output logic l);
    @(negedge clk);
    bus.RdReq = 1'b1;
    @(negedge clk);
    bus.RdReq = 1'b0;
    d = bus.RdData;
    v = bus.RdValid;
    l = bus.RdLast;
  endtask

  task automatic fill(input int k, input int n);
    for (int i = 0; i < n; i++) strobe(pat(k, i));
  endtask

  task automatic drain(input int k, input int n,
                       input string tag);
    logic [7:0] d;
    logic v, l;
    int errs;
    errs = 0;
    for (int i = 0; i < n; i++) begin
      rd(d, v, l);
      if (!v || d !== pat(k, i)) errs++;
      if (l !== (i == 511)) errs++;
    end
    check({tag, " data"}, errs, 0);
  endtask

  function automatic logic [14:0] outs();
    return {bus.BlockReq, bus.RdValid, bus.RdLast,
            bus.BanksFull, bus.Overflow, bus.Underflow,
            bus.ShortBlock, bus.RdData};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    logic v, l;
    int sp;
    bus.SD_Data = '0;
    bus.SD_DataClk = 1'b0;
    bus.SD_Enable = 1'b0;
    bus.RdReq = 1'b0;
    repeat (3) @(negedge clk);
    check("reset outs", outs(), 0);

    rst_n = 1'b1;
    bus.SD_Enable = 1'b1;
    repeat (4) @(negedge clk);
    check("idle blockreq", bus.BlockReq, 1);

    // Single block, bytes 0..255 twice
    fill(0, 512);
    check("t1 full", bus.BanksFull, 2'b01);
    check("t1 blockreq", bus.BlockReq, 1);
    drain(0, 512, "t1");
    check("t1 empty", bus.BanksFull, 2'b00);

    // Read from an empty bank
    rd(d, v, l);
    check("t4 valid", v, 0);
    check("t4 underflow", bus.Underflow, 1);
    check("t4 hold", d, 8'hFF);

    // Short block then a clean block at offset 0
    fill(5, 100);
    @(negedge clk);
    bus.SD_Enable = 1'b0;
    sp = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.ShortBlock) sp++;
    end
    check("t3 short pulse", sp, 1);
    check("t3 full", bus.BanksFull, 2'b00);
    bus.SD_Enable = 1'b1;
    repeat (4) @(negedge clk);
    fill(1, 512);
    check("t3 full b1", bus.BanksFull, 2'b10);
    drain(1, 512, "t3");

    // Both banks full, one extra byte
    fill(2, 512);
    fill(3, 512);
    check("t2 full", bus.BanksFull, 2'b11);
    check("t2 blockreq", bus.BlockReq, 0);
    strobe(8'hEE);
    check("t2 overflow", bus.Overflow, 1);
    check("t2 still full", bus.BanksFull, 2'b11);
    drain(2, 512, "t2 b0");
    drain(3, 512, "t2 b1");

    // Last write of bank1 coincides with last read of bank0
    fill(4, 512);
    fill(0, 511);
    drain(4, 511, "t5 b0");
    check("t5 pre", bus.BanksFull, 2'b01);
    @(negedge clk);
    bus.SD_Data = pat(0, 511);
    bus.SD_DataClk = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.SD_DataClk = 1'b0;
    bus.RdReq = 1'b1;
    @(negedge clk);
    bus.RdReq = 1'b0;
    check("t5 full", bus.BanksFull, 2'b10);
    check("t5 vld last", {bus.RdValid, bus.RdLast}, 2'b11);
    check("t5 data", bus.RdData, pat(4, 511));
    check("t5 blockreq", bus.BlockReq, 1);
    repeat (2) @(negedge clk);
    drain(0, 512, "t5 b1");

    // Reset in the middle of a block
    fill(5, 300);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6 async", outs(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("t6 blockreq", bus.BlockReq, 1);
    check("t6 full", bus.BanksFull, 2'b00);
    check("t6 sticky", {bus.Overflow, bus.Underflow}, 0);
    fill(1, 512);
    drain(1, 512, "t6");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
